// File: rtl/pin_vector_seq_pkg.sv
// -----------------------------------------------------------------------------
// tester_pkg
// Shared definitions for the pin vector sequencer slice: default geometry of
// the vector store and the playback state encoding.
// -----------------------------------------------------------------------------
package tester_pkg;

  localparam int NPINS_DEF = 8;   // tester pins driven
  localparam int DEPTH_DEF = 16;  // vector store entries, power of two
  localparam int RPT_W_DEF = 8;   // repeat-count width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pin_vector_seq_if.sv
// -----------------------------------------------------------------------------
// pin_vector_seq_if
// Control/data bundle of the pin vector sequencer.
//   master : the controller side (vector load, playback control, pin samples)
//   slave  : the sequencer side (pin drivers and status)
// Signals:
//   WR_EN, WR_D0, WR_D1, WR_DIR, WR_EXP, WR_RPT  vector load port
//   CLR, START, ABORT                            store / playback control
//   PIN_IN                                       sampled pin values
//   D0, D1, EN                                   per-pin driver data, EN=1 -> input
//   WR_FULL, BUSY, DONE, FAIL, FAIL_IDX, VEC_CNT status
// -----------------------------------------------------------------------------
interface pin_vector_seq_if
  import tester_pkg::*;
#(
  parameter int NPINS = NPINS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RPT_W = RPT_W_DEF
) ();

  logic                     WR_EN;
  logic [NPINS-1:0]         WR_D0;
  logic [NPINS-1:0]         WR_D1;
  logic [NPINS-1:0]         WR_DIR;
  logic [NPINS-1:0]         WR_EXP;
  logic [RPT_W-1:0]         WR_RPT;
  logic                     CLR;
  logic                     START;
  logic                     ABORT;
  logic [NPINS-1:0]         PIN_IN;

  logic [NPINS-1:0]         D0;
  logic [NPINS-1:0]         D1;
  logic [NPINS-1:0]         EN;
  logic                     WR_FULL;
  logic                     BUSY;
  logic                     DONE;
  logic                     FAIL;
  logic [$clog2(DEPTH)-1:0] FAIL_IDX;
  logic [$clog2(DEPTH):0]   VEC_CNT;

  modport master (
    output WR_EN, WR_D0, WR_D1, WR_DIR, WR_EXP, WR_RPT,
    output CLR, START, ABORT, PIN_IN,
    input  D0, D1, EN, WR_FULL, BUSY, DONE, FAIL, FAIL_IDX, VEC_CNT
  );

  modport slave (
    input  WR_EN, WR_D0, WR_D1, WR_DIR, WR_EXP, WR_RPT,
    input  CLR, START, ABORT, PIN_IN,
    output D0, D1, EN, WR_FULL, BUSY, DONE, FAIL, FAIL_IDX, VEC_CNT
  );

endinterface

// File: rtl/pin_vector_seq_store.sv
// -----------------------------------------------------------------------------
// vector_store
// Register file holding the test vectors: one synchronous write port and one
// asynchronous read port.
// Ports:
//   clk                                  write clock
//   we, waddr, w_d0/w_d1/w_dir/w_exp/w_rpt  write port
//   raddr, r_d0/r_d1/r_dir/r_exp/r_rpt      combinational read port
// -----------------------------------------------------------------------------
module vector_store
  import tester_pkg::*;
#(
  parameter int NPINS = NPINS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [NPINS-1:0]         w_d0,
  input  logic [NPINS-1:0]         w_d1,
  input  logic [NPINS-1:0]         w_dir,
  input  logic [NPINS-1:0]         w_exp,
  input  logic [RPT_W-1:0]         w_rpt,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [NPINS-1:0]         r_d0,
  output logic [NPINS-1:0]         r_d1,
  output logic [NPINS-1:0]         r_dir,
  output logic [NPINS-1:0]         r_exp,
  output logic [RPT_W-1:0]         r_rpt
);

  localparam int WW = 4 * NPINS + RPT_W;

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] rd_word;

  // NOTE: the array has no reset on purpose; validity is tracked by the
  // controller's entry count, so clearing the storage itself buys nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {w_d0, w_d1, w_dir, w_exp, w_rpt};
    end
  end

  assign rd_word = mem[raddr];
  assign {r_d0, r_d1, r_dir, r_exp, r_rpt} = rd_word;

endmodule

// File: rtl/pin_vector_seq.sv
// -----------------------------------------------------------------------------
// pin_vector_seq
// Loads up to DEPTH pin vectors and plays them back onto tester pin drivers.
// Each vector drives D0/D1, sets EN from its direction mask and is held for
// its repeat count + 1 cycles. On the last hold cycle the sampled pins are
// compared with the expected value on input pins; the first failing vector
// since START is recorded in FAIL_IDX and FAIL stays set until the next START.
// Ports:
//   C0   clock, all logic on the rising edge
//   RST  synchronous active-high reset
//   bus  pin_vector_seq_if.slave (load port, control, pin drivers, status)
// -----------------------------------------------------------------------------
module pin_vector_seq
  import tester_pkg::*;
#(
  parameter int NPINS = NPINS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic              C0,
  input  logic              RST,
  pin_vector_seq_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seq_state_e       state;
  logic [AW-1:0]    idx;        // vector currently on the pins
  logic [RPT_W-1:0] hold_cnt;   // hold cycles already spent on it
  logic [CW-1:0]    vec_cnt;
  logic [NPINS-1:0] d0_q;
  logic [NPINS-1:0] d1_q;
  logic [NPINS-1:0] en_q;       // doubles as the direction mask while running
  logic [NPINS-1:0] exp_q;
  logic [RPT_W-1:0] rpt_q;
  logic             fail_q;
  logic [AW-1:0]    fail_idx_q;

  logic [AW-1:0]    rd_addr;
  logic [NPINS-1:0] rd_d0;
  logic [NPINS-1:0] rd_d1;
  logic [NPINS-1:0] rd_dir;
  logic [NPINS-1:0] rd_exp;
  logic [RPT_W-1:0] rd_rpt;

  logic             wr_full;
  logic             wr_accept;
  logic             start_go;
  logic             last_hold;
  logic             last_vec;
  logic             mismatch;

  // The write pointer is the low part of the entry count: entries are only
  // ever appended, and CLR resets both together.
  vector_store #(
    .NPINS (NPINS),
    .DEPTH (DEPTH),
    .RPT_W (RPT_W)
  ) u_store (
    .clk   (C0),
    .we    (wr_accept),
    .waddr (vec_cnt[AW-1:0]),
    .w_d0  (bus.WR_D0),
    .w_d1  (bus.WR_D1),
    .w_dir (bus.WR_DIR),
    .w_exp (bus.WR_EXP),
    .w_rpt (bus.WR_RPT),
    .raddr (rd_addr),
    .r_d0  (rd_d0),
    .r_d1  (rd_d1),
    .r_dir (rd_dir),
    .r_exp (rd_exp),
    .r_rpt (rd_rpt)
  );

  // The read port always looks one vector ahead so the next vector can be
  // registered onto the pins on the edge that ends the current one. In IDLE
  // it points at vector 0, ready for START.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_addr = '0;
    if (state == RUN) begin
      rd_addr = idx + AW'(1);
    end
  end

  assign wr_full   = (vec_cnt == CW'(DEPTH));
  assign wr_accept = (state == IDLE) && bus.WR_EN && !wr_full && !bus.CLR;
  // CLR also blocks START so playback never runs against a count being zeroed.
  assign start_go  = (state == IDLE) && bus.START && !bus.ABORT && !bus.CLR &&
                     (vec_cnt != '0);
  assign last_hold = (hold_cnt == rpt_q);
  assign last_vec  = ({1'b0, idx} == (vec_cnt - CW'(1)));
  assign mismatch  = |((bus.PIN_IN ^ exp_q) & en_q);

  // NOTE: all state below is assigned with non-blocking <= so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge C0) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      vec_cnt    <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      en_q       <= '1;
      exp_q      <= '0;
      rpt_q      <= '0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CLR) begin
            vec_cnt <= '0;
          end else if (wr_accept) begin
            vec_cnt <= vec_cnt + CW'(1);
          end
          if (start_go) begin
            state      <= RUN;
            idx        <= '0;
            hold_cnt   <= '0;
            d0_q       <= rd_d0;
            d1_q       <= rd_d1;
            en_q       <= rd_dir;
            exp_q      <= rd_exp;
            rpt_q      <= rd_rpt;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
          end
        end

        RUN: begin
          if (bus.ABORT) begin
            state <= IDLE;
            d0_q  <= '0;
            d1_q  <= '0;
            en_q  <= '1;
          end else if (last_hold) begin
            if (mismatch) begin
              fail_q <= 1'b1;
              if (!fail_q) begin
                fail_idx_q <= idx;
              end
            end
            if (last_vec) begin
              state <= DONE_ST;
              d0_q  <= '0;
              d1_q  <= '0;
              en_q  <= '1;
            end else begin
              idx      <= idx + AW'(1);
              hold_cnt <= '0;
              d0_q     <= rd_d0;
              d1_q     <= rd_d1;
              en_q     <= rd_dir;
              exp_q    <= rd_exp;
              rpt_q    <= rd_rpt;
            end
          end else begin
            // Stops at rpt_q, so a full-scale repeat count never wraps.
            hold_cnt <= hold_cnt + RPT_W'(1);
          end
        end

        DONE_ST: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.D0       = d0_q;
  assign bus.D1       = d1_q;
  assign bus.EN       = en_q;
  assign bus.WR_FULL  = wr_full;
  assign bus.BUSY     = (state != IDLE);
  assign bus.DONE     = (state == DONE_ST);
  assign bus.FAIL     = fail_q;
  assign bus.FAIL_IDX = fail_idx_q;
  assign bus.VEC_CNT  = vec_cnt;

endmodule

// File: tb/tb_pin_vector_seq.sv
// -----------------------------------------------------------------------------
// tb_pin_vector_seq
// Directed bench for pin_vector_seq: a per-edge vector table for the playback
// runs plus hand-written sequences for the store-full, long-repeat and
// reset corner cases. Inputs change 1 ns after the rising edge, outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pin_vector_seq;
  import tester_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pin_vector_seq_if bus_if ();

  pin_vector_seq dut (
    .C0  (clk),
    .RST (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // One row per clock edge: inputs seen at the edge, outputs expected after.
  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] pin;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] en;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] fidx;
  } row_t;

  row_t rows[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] dir, input logic [7:0] exp,
                           input logic [7:0] rpt);
    bus_if.WR_D0  = d0;
    bus_if.WR_D1  = d1;
    bus_if.WR_DIR = dir;
    bus_if.WR_EXP = exp;
    bus_if.WR_RPT = rpt;
    bus_if.WR_EN  = 1'b1;
    step();
    bus_if.WR_EN  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // Playback of v0 (rpt 0), v1 (DIR 0F EXP 05, rpt 1), v2 (DIR F0 EXP A0, rpt 2).
    // Run 1: all pins match.
    rows.push_back('{1'b1, 1'b0, 8'h00, 8'h11, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h12, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h05, 8'h12, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h05, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'hA0, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'hA0, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'hA0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0});
    // Run 2: vector 1 sees 07 (fails), vector 2 sees 50 (fails again).
    rows.push_back('{1'b1, 1'b0, 8'h00, 8'h11, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h12, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h07, 8'h12, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h07, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b1, 4'd1});
    rows.push_back('{1'b0, 1'b0, 8'h50, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b1, 4'd1});
    rows.push_back('{1'b0, 1'b0, 8'h50, 8'h13, 8'h23, 8'hF0, 1'b1, 1'b0, 1'b1, 4'd1});
    rows.push_back('{1'b0, 1'b0, 8'h50, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd1});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd1});
    // Run 3: START clears FAIL, then ABORT during vector 1, no DONE.
    rows.push_back('{1'b1, 1'b0, 8'h00, 8'h11, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h12, 8'h22, 8'h0F, 1'b1, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0});
    // START and ABORT together in IDLE: ABORT wins.
    rows.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0});
    rows.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0});

    // ---- reset ----
    rst = 1'b1;
    bus_if.WR_EN  = 1'b0;
    bus_if.WR_D0  = '0;
    bus_if.WR_D1  = '0;
    bus_if.WR_DIR = '0;
    bus_if.WR_EXP = '0;
    bus_if.WR_RPT = '0;
    bus_if.CLR    = 1'b0;
    bus_if.START  = 1'b0;
    bus_if.ABORT  = 1'b0;
    bus_if.PIN_IN = '0;
    step();
    step();
    rst = 1'b0;
    check("rst d0",       bus_if.D0, 8'h00);
    check("rst d1",       bus_if.D1, 8'h00);
    check("rst en",       bus_if.EN, 8'hFF);
    check("rst busy",     bus_if.BUSY, 1'b0);
    check("rst done",     bus_if.DONE, 1'b0);
    check("rst fail",     bus_if.FAIL, 1'b0);
    check("rst fail_idx", bus_if.FAIL_IDX, 4'd0);
    check("rst vec_cnt",  bus_if.VEC_CNT, 5'd0);
    check("rst wr_full",  bus_if.WR_FULL, 1'b0);

    // ---- START with empty store is ignored ----
    bus_if.START = 1'b1;
    step();
    bus_if.START = 1'b0;
    check("empty start busy", bus_if.BUSY, 1'b0);
    check("empty start en",   bus_if.EN, 8'hFF);
    step();
    check("empty start busy later", bus_if.BUSY, 1'b0);

    // ---- load three vectors ----
    write_vec(8'h11, 8'h21, 8'h00, 8'h00, 8'd0);
    write_vec(8'h12, 8'h22, 8'h0F, 8'h05, 8'd1);
    write_vec(8'h13, 8'h23, 8'hF0, 8'hA0, 8'd2);
    check("load vec_cnt", bus_if.VEC_CNT, 5'd3);
    check("load wr_full", bus_if.WR_FULL, 1'b0);

    // ---- table-driven playback ----
    foreach (rows[i]) begin
      bus_if.START  = rows[i].start;
      bus_if.ABORT  = rows[i].abort;
      bus_if.PIN_IN = rows[i].pin;
      step();
      check($sformatf("row%0d d0", i),       bus_if.D0, rows[i].d0);
      check($sformatf("row%0d d1", i),       bus_if.D1, rows[i].d1);
      check($sformatf("row%0d en", i),       bus_if.EN, rows[i].en);
      check($sformatf("row%0d busy", i),     bus_if.BUSY, rows[i].busy);
      check($sformatf("row%0d done", i),     bus_if.DONE, rows[i].done);
      check($sformatf("row%0d fail", i),     bus_if.FAIL, rows[i].fail);
      check($sformatf("row%0d fail_idx", i), bus_if.FAIL_IDX, rows[i].fidx);
    end
    bus_if.START  = 1'b0;
    bus_if.ABORT  = 1'b0;
    bus_if.PIN_IN = '0;
    check("persist vec_cnt", bus_if.VEC_CNT, 5'd3);

    // ---- full-scale repeat count, writes and CLR ignored while running ----
    bus_if.CLR = 1'b1;
    step();
    bus_if.CLR = 1'b0;
    check("clr vec_cnt", bus_if.VEC_CNT, 5'd0);
    write_vec(8'h5A, 8'hA5, 8'h00, 8'h00, 8'hFF);
    bus_if.START = 1'b1;
    step();
    bus_if.START = 1'b0;
    cnt = 0;
    while (bus_if.D0 == 8'h5A && cnt < 400) begin
      cnt++;
      bus_if.WR_EN = (cnt == 10);
      bus_if.CLR   = (cnt == 10);
      step();
    end
    bus_if.WR_EN = 1'b0;
    bus_if.CLR   = 1'b0;
    check("max rpt hold cycles", cnt, 256);
    check("max rpt done",        bus_if.DONE, 1'b1);
    step();
    check("max rpt idle busy",   bus_if.BUSY, 1'b0);
    check("run write/clr dropped vec_cnt", bus_if.VEC_CNT, 5'd1);

    // ---- reset in the middle of playback ----
    bus_if.START = 1'b1;
    step();
    bus_if.START = 1'b0;
    step();
    check("mid run d0", bus_if.D0, 8'h5A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst d0",      bus_if.D0, 8'h00);
    check("mid rst d1",      bus_if.D1, 8'h00);
    check("mid rst en",      bus_if.EN, 8'hFF);
    check("mid rst busy",    bus_if.BUSY, 1'b0);
    check("mid rst done",    bus_if.DONE, 1'b0);
    check("mid rst vec_cnt", bus_if.VEC_CNT, 5'd0);
    step();
    check("after rst busy",  bus_if.BUSY, 1'b0);

    // ---- fill the store past its depth ----
    for (int i = 0; i < 16; i++) begin
      write_vec(8'(i), 8'h00, 8'h00, 8'h00, 8'd0);
      if (i == 14) begin
        check("fill 15 wr_full", bus_if.WR_FULL, 1'b0);
        check("fill 15 vec_cnt", bus_if.VEC_CNT, 5'd15);
      end
    end
    check("fill 16 wr_full", bus_if.WR_FULL, 1'b1);
    check("fill 16 vec_cnt", bus_if.VEC_CNT, 5'd16);
    write_vec(8'hEE, 8'hEE, 8'h00, 8'h00, 8'd0);
    check("fill 17 vec_cnt", bus_if.VEC_CNT, 5'd16);
    check("fill 17 wr_full", bus_if.WR_FULL, 1'b1);

    // Play the full store back: one cycle per vector, D0 = index.
    bus_if.START = 1'b1;
    step();
    bus_if.START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("full play d0 %0d", k), bus_if.D0, 8'(k));
      step();
    end
    check("full play done", bus_if.DONE, 1'b1);
    check("full play fail", bus_if.FAIL, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_vector_seq.md
PIN_VECTOR_SEQ -- requirements
Module: pin_vector_seq

Interface
REQ-001 SHALL have parameter NPINS, default 8, number of tester pins driven.
REQ-002 SHALL have parameter DEPTH, default 16, vector store entries (power of 2).
REQ-003 SHALL have parameter RPT_W, default 8, repeat-count width.
REQ-004 SHALL have ports: C0 in 1, the single clock, all logic on rising edge.
REQ-005 SHALL have ports: RST in 1, reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: WR_EN in 1, load one vector; WR_D0/WR_D1/WR_DIR/WR_EXP in NPINS each, rising/falling data, direction (1=input), expected input value; WR_RPT in RPT_W, hold count.
REQ-007 SHALL have ports: CLR in 1, empty store; START in 1, begin playback; ABORT in 1, stop playback.
REQ-008 SHALL have ports: PIN_IN in NPINS, sampled pin values.
REQ-009 SHALL have ports: D0, D1, EN out NPINS, per-pin driver data and tristate enable (EN high = pin is input).
REQ-010 SHALL have ports: WR_FULL, BUSY, DONE, FAIL out 1; FAIL_IDX out log2(DEPTH); VEC_CNT out log2(DEPTH)+1, entries stored.

Function
REQ-011 SHALL accept WR_EN only in IDLE with VEC_CNT<DEPTH, storing at write pointer, incrementing VEC_CNT; writes when full or not IDLE SHALL be dropped.
REQ-012 SHALL assert WR_FULL combinationally when VEC_CNT==DEPTH.
REQ-013 SHALL implement states IDLE, RUN, DONE_ST.
REQ-014 IDLE->RUN on START with VEC_CNT>0 and ABORT low; START with empty store SHALL be ignored.
REQ-015 In RUN, vector i SHALL appear on D0/D1/EN (EN=WR_DIR) from the edge after it is selected and be held WR_RPT+1 cycles; vector 0 appears on the edge START is sampled.
REQ-016 On the last hold cycle of each vector, SHALL compare (PIN_IN ^ EXP) & DIR; nonzero sets FAIL sticky and, if first failure since START, captures index into FAIL_IDX.
REQ-017 After last hold cycle of vector VEC_CNT-1, SHALL enter DONE_ST for one cycle with DONE=1, then IDLE.
REQ-018 START in RUN or DONE_ST SHALL be ignored; START in IDLE SHALL clear FAIL and FAIL_IDX.
REQ-019 ABORT in RUN SHALL return to IDLE next edge without DONE; ABORT and START together in IDLE: ABORT wins.
REQ-020 Outside RUN, SHALL drive D0=D1=0, EN=all ones (all pins high-Z).
REQ-021 Store contents SHALL persist across playbacks; CLR in IDLE SHALL zero VEC_CNT and pointers; CLR outside IDLE ignored.
REQ-022 BUSY SHALL be 1 in RUN and DONE_ST.
REQ-023 WR_RPT=2^RPT_W-1 SHALL hold 2^RPT_W cycles without counter overflow.

Reset
REQ-024 On RST: state IDLE, VEC_CNT=0, pointers 0, FAIL=0, FAIL_IDX=0, DONE=0, BUSY=0, D0=D1=0, EN=all ones.
REQ-025 RST mid-RUN SHALL take effect at next edge, overriding all other inputs; stored vectors are lost.

Structure
REQ-026 NPINS, DEPTH, RPT_W defaults and state encoding SHALL live in shared package tester_pkg.
REQ-027 Vector storage SHALL be sub-module vector_store (synchronous write, asynchronous read register file).

Verification
REQ-028 Load 3 vectors RPT=0,1,2, START -> outputs hold 1,2,3 cycles, DONE pulses 6 cycles after START edge, FAIL=0.
REQ-029 Vector 1 DIR=0x0F, EXP=0x05, PIN_IN=0x07 -> FAIL=1, FAIL_IDX=1; later mismatch on vector 2 leaves FAIL_IDX=1.
REQ-030 Write DEPTH+1 vectors -> WR_FULL=1 after 16th, VEC_CNT=16, 17th dropped.
REQ-031 ABORT during vector 1 -> next edge EN=0xFF, D0=D1=0, BUSY=0, no DONE.
REQ-032 START with empty store -> stays IDLE; START+ABORT same cycle -> stays IDLE.
REQ-033 RST asserted mid-RUN -> all outputs at reset values next edge, VEC_CNT=0.
